// File: rtl/muldiv_pkg.sv
// Shared types, opcodes and operand helpers for the iterative RV64M multiply/divide unit.
// The optional early-out path in muldiv_sequencer is enabled by MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned PW        = 2 * XLEN;
    localparam int unsigned MUL_STEPS = 64;
    localparam int unsigned CNT_W     = 7;

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OP_MULDIV_F7 = 7'b0000001;

    // Word ops look only at bits [31:0], extended according to signedness.
    function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] v,
                                                    input logic word,
                                                    input logic sgn);
        if (!word)
            return v;
        return {{32{sgn & v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] cond_neg_wide(input logic [PW-1:0] v, input logic neg);
        return neg ? (~v + PW'(1)) : v;
    endfunction

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide: one shift-add or restoring-subtract step per cycle.
// Define MULDIV_EARLY_OUT_EN to short-cut special divides and exhausted multipliers.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t   state, state_next;
    logic [2:0]      f3_r;
    logic            word_r;
    logic [XLEN-1:0] a_r, b_r;
    logic [XLEN-1:0] acc, lo, mcand;
    logic [CNT_W-1:0] count;
    logic            neg_q, neg_r, div0, ovf;

    // Operand preparation, evaluated while in PREP.
    logic            sgn_a, sgn_b, sa, sb, div0_c, ovf_c;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_val;
    logic [CNT_W-1:0] steps;

    assign sgn_a   = (f3_r != F3_MULHU) && (f3_r != F3_DIVU) && (f3_r != F3_REMU);
    assign sgn_b   = sgn_a && (f3_r != F3_MULHSU);
    assign ext_a   = ext_operand(a_r, word_r, sgn_a);
    assign ext_b   = ext_operand(b_r, word_r, sgn_b);
    assign sa      = sgn_a & ext_a[XLEN-1];
    assign sb      = sgn_b & ext_b[XLEN-1];
    assign mag_a   = cond_neg(ext_a, sa);
    assign mag_b   = cond_neg(ext_b, sb);
    assign min_val = word_r ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div0_c  = f3_r[2] && (ext_b == '0);
    assign ovf_c   = f3_r[2] && sgn_b && (ext_a == min_val) && (ext_b == '1);
    assign steps   = word_r ? CNT_W'(MUL_STEPS / 2) : CNT_W'(MUL_STEPS);

    // One iteration of each algorithm.
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            rem_ge;

    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    assign rem_sh  = {acc, lo[XLEN-1]};
    assign rem_ge  = rem_sh >= {1'b0, mcand};
    assign rem_sub = rem_sh[XLEN-1:0] - mcand;

    logic            mul_early, prep_skip;
    logic [PW-1:0]   prod;

`ifdef MULDIV_EARLY_OUT_EN
    // Unconsumed multiplier bits sit in lo[count-1:0]; once zero, only shifts remain.
    assign mul_early = (state == RUN) && !f3_r[2] &&
                       ((lo & ((XLEN'(1) << count) - XLEN'(1))) == '0);
    assign prep_skip = div0_c | ovf_c;
    assign prod      = {acc, lo} >> count;
`else
    assign mul_early = 1'b0;
    assign prep_skip = 1'b0;
    assign prod      = {acc, lo};
`endif

    // Result formatting, evaluated while in FIX.
    logic [PW-1:0]   prod_al, prod_s;
    logic [XLEN-1:0] quot, rem, field, fix_result;
    logic            illegal;

    assign prod_al = word_r ? {{XLEN{1'b0}}, prod[95:32]} : prod;
    assign prod_s  = cond_neg_wide(prod_al, neg_q);
    assign quot    = div0 ? '1 : (ovf ? a_r : cond_neg(lo, neg_q));
    assign rem     = div0 ? a_r : (ovf ? '0 : cond_neg(acc, neg_r));
    assign illegal = word_r && (f3_r inside {F3_MULH, F3_MULHSU, F3_MULHU});

    always_comb begin
        field = '0;
        case (f3_r)
            F3_MUL:                      field = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: field = prod_s[PW-1:XLEN];
            F3_DIV, F3_DIVU:             field = quot;
            default:                     field = rem;
        endcase
        fix_result = illegal ? '0 : (word_r ? sext_word(field) : field);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = PREP;
            PREP: state_next = prep_skip ? FIX : RUN;
            RUN:  if (mul_early || count == CNT_W'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, registered outputs and the shared shift datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            f3_r   <= '0;
            word_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            lo     <= '0;
            mcand  <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= state_next != IDLE;
            done  <= state_next == DONE;
            case (state)
                IDLE: if (start) begin
                    f3_r   <= funct3;
                    word_r <= word;
                    a_r    <= op_a;
                    b_r    <= op_b;
                end
                PREP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    div0  <= div0_c;
                    ovf   <= ovf_c;
                    count <= steps;
                    acc   <= '0;
                    mcand <= f3_r[2] ? mag_b : mag_a;
                    if (f3_r[2])
                        lo <= word_r ? {mag_a[31:0], 32'b0} : mag_a;
                    else
                        lo <= mag_b;
                end
                RUN: if (!mul_early) begin
                    count <= count - CNT_W'(1);
                    if (f3_r[2]) begin
                        acc <= rem_ge ? rem_sub : rem_sh[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], rem_ge};
                    end else begin
                        acc <= mul_sum[XLEN:1];
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                FIX: result <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer plus reset-in-RUN and start-while-busy sequences.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic        word;
    logic [63:0] op_a, op_b;
    logic        busy, done;
    logic [63:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    muldiv_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .word   (word),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        logic        spec;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Expected latency; -1 means data-dependent (early-out multiplies).
    function automatic int lat_of(input logic [2:0] f3, input logic spec, input int lat);
        if (EARLY && spec) return 3;
        if (EARLY && !f3[2]) return -1;
        return lat;
    endfunction

    task automatic run_op(input string nm, input logic [2:0] f3v, input logic wv,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] ev, input int lat);
        int   cyc;
        logic busy_ok;
        logic got;
        @(negedge clk);
        funct3 = f3v; word = wv; op_a = av; op_b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = ~av; op_b = ~bv;
        cyc = 1; busy_ok = 1'b1; got = 1'b0;
        while (!got && cyc <= 200) begin
            if (!busy) busy_ok = 1'b0;
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({nm, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, " result"}, result, ev);
            chk({nm, " busy_while_active"}, 64'(busy_ok), 64'd1);
            if (lat >= 0) chk({nm, " latency"}, 64'(cyc), 64'(lat));
            @(posedge clk); #1;
            chk({nm, " after_done_busy_done"}, {62'd0, busy, done}, 64'd0);
            chk({nm, " result_held"}, result, ev);
        end
    endtask

    initial begin
        vecs[0]  = '{F3_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67, 1'b0};
        vecs[1]  = '{F3_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67, 1'b0};
        vecs[2]  = '{F3_MULH,   1'b0, '1, '1, 64'd0, 67, 1'b0};
        vecs[3]  = '{F3_DIV,    1'b0, 64'd100, 64'd0, '1, 67, 1'b1};
        vecs[4]  = '{F3_REM,    1'b0, 64'd100, 64'd0, 64'd100, 67, 1'b1};
        vecs[5]  = '{F3_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 67, 1'b1};
        vecs[6]  = '{F3_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 67, 1'b1};
        vecs[7]  = '{F3_DIV,    1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 35, 1'b0};
        vecs[8]  = '{F3_REMU,   1'b1, 64'hAAAA_0000_0000_0007, 64'h5555_0000_0000_0002, 64'd1, 35, 1'b0};
        vecs[9]  = '{F3_MUL,    1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 35, 1'b0};
        vecs[10] = '{F3_MULHSU, 1'b0, '1, 64'd2, '1, 67, 1'b0};
        vecs[11] = '{F3_MULH,   1'b1, 64'd5, 64'd5, 64'd0, 35, 1'b0};
        vecs[12] = '{F3_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 67, 1'b0};
        vecs[13] = '{F3_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 67, 1'b0};
        vecs[14] = '{F3_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 1'b0};
        vecs[15] = '{F3_MULHU,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 67, 1'b0};
        vecs[16] = '{F3_REM,    1'b1, 64'h1111_1111_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 35, 1'b1};
        vecs[17] = '{F3_DIV,    1'b1, 64'h1111_1111_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 35, 1'b1};
        vecs[18] = '{F3_DIVU,   1'b0, 64'd123, 64'd0, '1, 67, 1'b1};

        reset = 1'b1; start = 1'b0; funct3 = '0; word = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b,
                   vecs[i].exp, lat_of(vecs[i].f3, vecs[i].spec, vecs[i].lat));

        // Reset asserted while the multiply loop is running.
        @(negedge clk);
        funct3 = F3_MUL; word = 1'b0; op_a = 64'h1234; op_b = 64'h8000_0000_0000_0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 20; c++) @(posedge clk);
        #1;
        chk("midrun busy_before_reset", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun reset busy", 64'(busy), 64'd0);
        chk("midrun reset done", 64'(done), 64'd0);
        chk("midrun reset result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset mul5x5", F3_MUL, 1'b0, 64'd5, 64'd5, 64'd25, EARLY ? -1 : 67);

        // Start pulses while busy (including the DONE cycle) must be dropped.
        begin
            int n_done;
            int done_cyc;
            n_done = 0; done_cyc = 0;
            @(negedge clk);
            funct3 = F3_DIV; word = 1'b0; op_a = 64'd1000; op_b = 64'd10; start = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= 90; c++) begin
                #1;
                if (done) begin
                    n_done++;
                    done_cyc = c;
                end
                @(negedge clk);
                start = (c == 10 || c == 66 || c == 67);
                funct3 = F3_MUL; op_a = 64'd3; op_b = 64'd3;
                @(posedge clk);
            end
            #1;
            chk("busy_start done_count", 64'(n_done), 64'd1);
            chk("busy_start done_cycle", 64'(done_cyc), 64'd67);
            chk("busy_start result", result, 64'd100);
            chk("busy_start idle_after", 64'(busy), 64'd0);
            start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
